// File: rtl/ckt_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module      : ckt_sweep_if
//  Description : Bundle between the sweep sequencer and its environment:
//                start request, stimulus x/y/z, circuit responses, status
//                and captured truth tables. The optional checker adds
//                expected tables and error outputs (macro SWEEP_CHECK_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ckt_sweep_if;
    logic       start;
    logic       x;
    logic       y;
    logic       z;
    logic       f1_in;
    logic       f2_in;
    logic       busy;
    logic       done;
    logic [7:0] tt_f1;
    logic [7:0] tt_f2;
`ifdef SWEEP_CHECK_EN
    logic [7:0] exp_f1;
    logic [7:0] exp_f2;
    logic [4:0] err_count;
    logic       mismatch;

    // Environment side: requests sweeps, returns circuit responses.
    modport master (
        output start, f1_in, f2_in, exp_f1, exp_f2,
        input  x, y, z, busy, done, tt_f1, tt_f2, err_count, mismatch
    );

    // Sequencer side.
    modport slave (
        input  start, f1_in, f2_in, exp_f1, exp_f2,
        output x, y, z, busy, done, tt_f1, tt_f2, err_count, mismatch
    );
`else
    // Environment side: requests sweeps, returns circuit responses.
    modport master (
        output start, f1_in, f2_in,
        input  x, y, z, busy, done, tt_f1, tt_f2
    );

    // Sequencer side.
    modport slave (
        input  start, f1_in, f2_in,
        output x, y, z, busy, done, tt_f1, tt_f2
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ckt_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : ckt_sweep
//  Description : Exhaustive 3-input stimulus sequencer with response capture.
//                Drives {x,y,z} = 0..7, holds each for HOLD_CYCLES cycles,
//                samples F1/F2 on the last hold cycle into 8-bit truth
//                tables and pulses done. Optional on-the-fly comparison
//                against expected tables is enabled by SWEEP_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ckt_sweep #(
    parameter int HOLD_CYCLES = 4        // legal range 1..255
) (
    input  logic         clk,
    input  logic         rst,
    ckt_sweep_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last count value of a hold period; sampling happens when cnt reaches it.
    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q,   idx_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] tt_f1_q, tt_f1_d;
    logic [7:0] tt_f2_q, tt_f2_d;
    logic       w_sample;

`ifdef SWEEP_CHECK_EN
    logic [4:0] err_q, err_d;
    logic       mism_q, mism_d;
    logic [4:0] w_err_inc;

    // Number of mismatching responses at the current combination (0..2).
    assign w_err_inc = 5'(bus.f1_in != bus.exp_f1[idx_q])
                     + 5'(bus.f2_in != bus.exp_f2[idx_q]);
`endif

    assign w_sample = (state_q == S_RUN) && (cnt_q == C_HOLD_LAST);

    // State and datapath registers; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            tt_f1_q <= 8'd0;
            tt_f2_q <= 8'd0;
`ifdef SWEEP_CHECK_EN
            err_q   <= 5'd0;
            mism_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_f1_q <= tt_f1_d;
            tt_f2_q <= tt_f2_d;
`ifdef SWEEP_CHECK_EN
            err_q   <= err_d;
            mism_q  <= mism_d;
`endif
        end
    end

    // Next-state logic: start acceptance, hold counting and sampling.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_f1_d = tt_f1_q;
        tt_f2_d = tt_f2_q;
`ifdef SWEEP_CHECK_EN
        err_d   = err_q;
        mism_d  = mism_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // A new sweep wipes previous results and checker state.
                    state_d = S_RUN;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    tt_f1_d = 8'd0;
                    tt_f2_d = 8'd0;
`ifdef SWEEP_CHECK_EN
                    err_d   = 5'd0;
                    mism_d  = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!w_sample) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    tt_f1_d[idx_q] = bus.f1_in;
                    tt_f2_d[idx_q] = bus.f2_in;
`ifdef SWEEP_CHECK_EN
                    err_d = err_q + w_err_inc;
                    if (w_err_inc != 5'd0) begin
                        mism_d = 1'b1;
                    end
`endif
                    if (idx_q == 3'd7) begin
                        // Park stimulus at 000 while reporting completion.
                        state_d = S_DONE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stimulus comes straight from the registered index, x is the MSB.
    assign bus.x     = idx_q[2];
    assign bus.y     = idx_q[1];
    assign bus.z     = idx_q[0];
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.tt_f1 = tt_f1_q;
    assign bus.tt_f2 = tt_f2_q;
`ifdef SWEEP_CHECK_EN
    assign bus.err_count = err_q;
    assign bus.mismatch  = mism_q;
`endif

endmodule
`default_nettype wire
